med_block_packer: RTL and testbench

Write-side packer for the median PDP kernel block register. It accepts a narrow valid/ready stream of int8 pixel bytes and assembles a full 8 x 112-bit block (8 lanes of 14 bytes).
It then presents the block on a valid/ready output whose accept strobe drives the block register's load enable. It decouples the byte-serial traceplayer/DMA feed from the wide Med2D core window input.

---
 rtl/med_pack_pkg.sv | 16 +
 rtl/med_pack_ctrl.sv | 56 +++++
 rtl/med_block_packer.sv | 74 +++++++
 tb/tb_med_block_packer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/med_pack_pkg.sv
// Shared constants and types for the median PDP block packer.
// Block byte k sits at lane k/14, bits (k%14)*8, i.e. flat bit k*8.
package med_pack_pkg;

    localparam int LANES          = 8;
    localparam int LANE_W         = 112;
    localparam int BYTES_PER_LANE = LANE_W / 8;

    typedef logic [LANE_W-1:0] lane_t;
    typedef lane_t [LANES-1:0] block_t;

    function automatic int beats_for(input int beat_bytes);
        return LANES * BYTES_PER_LANE / beat_bytes;
    endfunction

endpackage

// File: rtl/med_pack_ctrl.sv
// Beat counter, start-of-block recovery, output handshake and block count
// for the median block packer.
module med_pack_ctrl #(
    parameter int BEATS = 56,
    parameter int IW    = $clog2(BEATS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic          in_sob,
    input  logic          out_ready,
    output logic          in_ready,
    output logic          wr_en,
    output logic [IW-1:0] wr_idx,
    output logic          blk_done,
    output logic          out_valid,
    output logic          out_load,
    output logic          err_sob,
    output logic [15:0]   blk_cnt
);

    localparam logic [IW-1:0] LAST = IW'(BEATS - 1);

    logic [IW-1:0] beat_cnt;
    logic          restart;
    logic          at_last;

    // Only the final beat can collide with a held block.
    assign at_last  = beat_cnt == LAST;
    assign in_ready = ~(out_valid & ~out_ready & at_last);
    assign wr_en    = in_valid & in_ready;
    assign restart  = wr_en & in_sob & (beat_cnt != '0);
    assign wr_idx   = restart ? '0 : beat_cnt;
    assign blk_done = wr_en & (wr_idx == LAST);
    assign out_load = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            err_sob   <= 1'b0;
            blk_cnt   <= '0;
        end else begin
            err_sob <= restart;
            if (wr_en)
                beat_cnt <= blk_done ? '0 : wr_idx + 1'b1;
            if (blk_done)
                out_valid <= 1'b1;
            else if (out_load)
                out_valid <= 1'b0;
            if (out_load)
                blk_cnt <= blk_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/med_block_packer.sv
// Byte-serial to 8 x 112-bit block packer feeding the Med2D block register.
// The output register loads the buffer plus the in-flight final beat.
module med_block_packer
    import med_pack_pkg::*;
#(
    parameter int BEAT_BYTES = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [8*BEAT_BYTES-1:0]       in_data,
    input  logic                          in_valid,
    input  logic                          in_sob,
    output logic                          in_ready,
    output logic [LANES-1:0][LANE_W-1:0]  out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_load,
    output logic                          err_sob,
    output logic [15:0]                   blk_cnt
);

    localparam int BEATS = beats_for(BEAT_BYTES);
    localparam int IW    = $clog2(BEATS);
    localparam int BW    = 8 * BEAT_BYTES;

    logic                      wr_en;
    logic                      blk_done;
    logic [IW-1:0]             wr_idx;
    logic [LANES*LANE_W-1:0]   asm_q;
    logic [LANES*LANE_W-1:0]   asm_d;
    block_t                    out_q;

    med_pack_ctrl #(
        .BEATS (BEATS),
        .IW    (IW)
    ) u_ctrl (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_sob    (in_sob),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .blk_done  (blk_done),
        .out_valid (out_valid),
        .out_load  (out_load),
        .err_sob   (err_sob),
        .blk_cnt   (blk_cnt)
    );

    // Beat decoder: a beat is a contiguous byte run within one lane.
    always_comb begin
        asm_d = asm_q;
        for (int b = 0; b < BEATS; b++) begin
            if (wr_en && wr_idx == IW'(b))
                asm_d[b*BW +: BW] = in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            asm_q <= '0;
            out_q <= '0;
        end else begin
            asm_q <= asm_d;
            if (blk_done)
                out_q <= block_t'(asm_d);
        end
    end

    assign out_data = out_q;

endmodule

// File: tb/tb_med_block_packer.sv
// Scoreboarded bench for med_block_packer at BEAT_BYTES=2.
// Inputs change on negedge; outputs sampled 1 time unit before posedge.
module tb_med_block_packer;

    localparam int BB = 2;
    localparam int NB = 56;

    typedef logic [7:0][111:0] blk_t;

    typedef struct {
        int         lane;
        int         byt;
        logic [7:0] exp;
    } vec_t;

    logic        clk = 1'b1;
    logic        reset_n = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_sob = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    blk_t        out_data;
    logic        out_valid;
    logic        out_load;
    logic        err_sob;
    logic [15:0] blk_cnt;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          mcnt = 0;
    int          nload = 0;
    int          nerr = 0;
    logic        mvalid = 1'b0;
    logic        merr = 1'b0;
    logic        acc_seen = 1'b0;
    logic [15:0] mblk = '0;
    blk_t        mb = '0;
    blk_t        last_blk = '0;
    blk_t        sbq[$];
    int          ldcyc[$];
    vec_t        vt[6];

    med_block_packer #(.BEAT_BYTES(BB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sob    (in_sob),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_load  (out_load),
        .err_sob   (err_sob),
        .blk_cnt   (blk_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s cyc=%0d", nm, cyc);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_blk(input string nm, input blk_t act, input blk_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            for (int l = 0; l < 8; l++) begin
                if (act[l] !== exp[l]) begin
                    $display("FAIL %s lane=%0d act=%h exp=%h cyc=%0d",
                             nm, l, act[l], exp[l], cyc);
                    break;
                end
            end
        end
    endtask

    function automatic logic [7:0] bv(input int s, input int k);
        return 8'(s * 37 + k);
    endfunction

    function automatic logic [15:0] bw(input int s, input int i);
        return {bv(s, 2*i+1), bv(s, 2*i)};
    endfunction

    task automatic tick();
        logic rdy;
        logic ld;
        logic acc;
        logic done;
        int   k;
        blk_t e;
        #4;
        cyc++;
        rdy = !(mvalid && !out_ready && mcnt == NB-1);
        ld  = mvalid && out_ready;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("out_valid", 32'(out_valid), 32'(mvalid));
        chk("err_sob", 32'(err_sob), 32'(merr));
        chk("out_load", 32'(out_load), 32'(ld));
        if (err_sob)
            nerr++;
        if (mvalid) begin
            if (sbq.size() == 0)
                fail("scoreboard_empty");
            else
                chk_blk("out_data", out_data, sbq[0]);
        end
        if (ld) begin
            chk("blk_cnt", 32'(blk_cnt), 32'(mblk));
            mblk++;
            nload++;
            ldcyc.push_back(cyc);
            last_blk = out_data;
            if (sbq.size() > 0)
                e = sbq.pop_front();
        end
        acc  = in_valid && rdy;
        merr = 1'b0;
        done = 1'b0;
        if (acc) begin
            if (in_sob && mcnt != 0) begin
                merr = 1'b1;
                mcnt = 0;
            end
            for (int j = 0; j < BB; j++) begin
                k = mcnt * BB + j;
                mb[k/14][(k%14)*8 +: 8] = in_data[j*8 +: 8];
            end
            if (mcnt == NB-1) begin
                sbq.push_back(mb);
                mcnt = 0;
                done = 1'b1;
            end else begin
                mcnt++;
            end
        end
        if (done)
            mvalid = 1'b1;
        else if (ld)
            mvalid = 1'b0;
        acc_seen = acc;
        @(negedge clk);
    endtask

    task automatic beat(input logic [15:0] d, input logic sob);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sob   = sob;
        do begin
            tick();
            n++;
        end while (!acc_seen && n < 200);
        if (!acc_seen)
            fail("beat_timeout");
        in_sob = 1'b0;
    endtask

    task automatic send(input int s, input bit sob, input int nb);
        for (int i = 0; i < nb; i++)
            beat(bw(s, i), sob && i == 0);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sob   = 1'b0;
        repeat (n) tick();
    endtask

    // Entered at a negedge; leaves reset released at a later negedge.
    task automatic do_reset();
        #1 reset_n = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_err_sob", 32'(err_sob), 32'd0);
        chk("rst_blk_cnt", 32'(blk_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_load", 32'(out_load), 32'd0);
        chk_blk("rst_out_data", out_data, '0);
        @(negedge clk);
        reset_n = 1'b1;
        sbq.delete();
        mcnt   = 0;
        mvalid = 1'b0;
        merr   = 1'b0;
        mblk   = '0;
    endtask

    initial begin
        int n0;
        int e0;
        int nl;
        vt[0] = '{0, 0, 8'h00};
        vt[1] = '{0, 1, 8'h01};
        vt[2] = '{1, 0, 8'h0E};
        vt[3] = '{7, 13, 8'h6F};
        vt[4] = '{3, 5, 8'h2F};
        vt[5] = '{6, 13, 8'h61};

        @(negedge clk);
        do_reset();

        // Basic fill: block byte k carries value k
        out_ready = 1'b1;
        send(0, 1, NB);
        idle(3);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t1_byte_l%0d_b%0d", vt[i].lane, vt[i].byt),
                32'(last_blk[vt[i].lane][vt[i].byt*8 +: 8]),
                32'(vt[i].exp));
        chk("t1_blk_cnt", 32'(blk_cnt), 32'd1);
        chk("t1_no_err", 32'(nerr), 32'd0);

        // Backpressure: second block's last beat stalls until out_ready
        n0 = nload;
        out_ready = 1'b0;
        send(1, 1, NB);
        send(2, 0, NB-1);
        in_valid = 1'b1;
        in_data  = bw(2, NB-1);
        repeat (3) begin
            tick();
            chk("t2_stall", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        beat(bw(2, NB-1), 1'b0);
        idle(3);
        chk("t2_loads", 32'(nload - n0), 32'd2);

        // Continuous stream of three blocks
        n0 = nload;
        send(10, 0, NB);
        send(11, 0, NB);
        send(12, 0, NB);
        idle(3);
        nl = ldcyc.size();
        chk("t3_loads", 32'(nload - n0), 32'd3);
        chk("t3_gap_a", 32'(ldcyc[nl-1] - ldcyc[nl-2]), 32'd56);
        chk("t3_gap_b", 32'(ldcyc[nl-2] - ldcyc[nl-3]), 32'd56);
        chk("t3_blk_cnt", 32'(blk_cnt), 32'd6);

        // Mid-block sob discards 20 beats
        n0 = nload;
        e0 = nerr;
        send(4, 1, 20);
        send(5, 1, NB);
        idle(3);
        chk("t4_err_pulses", 32'(nerr - e0), 32'd1);
        chk("t4_loads", 32'(nload - n0), 32'd1);

        // Reset while a block is held and another is half built
        out_ready = 1'b0;
        send(6, 0, NB);
        send(7, 0, 30);
        in_valid = 1'b0;
        do_reset();
        out_ready = 1'b1;
        send(8, 1, NB);
        idle(3);
        chk("t5_blk_cnt", 32'(blk_cnt), 32'd1);

        // Block counter wrap
        force dut.u_ctrl.blk_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.u_ctrl.blk_cnt;
        mblk = 16'hFFFF;
        send(9, 1, NB);
        idle(3);
        chk("t6_wrap", 32'(blk_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
